// File: rtl/fpu_square_seq_if.sv
// Enable/done handshake bundle shared by the FPU arithmetic units.
// The sequencer drives enable/operand_in; the unit returns result, done and flags.
interface fpu_square_seq_if;
    logic        enable;
    logic [79:0] operand_in;
    logic [79:0] result;
    logic        done;
    logic        flag_invalid;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    modport master (
        output enable,
        output operand_in,
        input  result,
        input  done,
        input  flag_invalid,
        input  flag_overflow,
        input  flag_underflow,
        input  flag_inexact
    );

    modport slave (
        input  enable,
        input  operand_in,
        output result,
        output done,
        output flag_invalid,
        output flag_overflow,
        output flag_underflow,
        output flag_inexact
    );
endinterface

// File: rtl/fpu_square_seq.sv
// Sequential FP80 squarer: classify, radix-2 shift-add mantissa multiply,
// then round-to-nearest-even with saturation to +Inf / flush to +0.
module fpu_square_seq (
    input  logic              clk,
    input  logic              reset,
    fpu_square_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_MUL   = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Flag vector order: {invalid, overflow, underflow, inexact}
    localparam logic [3:0] FLAG_NV = 4'b1000;
    localparam logic [3:0] FLAG_OF = 4'b0100;
    localparam logic [3:0] FLAG_UF = 4'b0010;
    localparam logic [3:0] FLAG_NX = 4'b0001;

    localparam logic [79:0] POS_INF    = 80'h7FFF_8000_0000_0000_0000;
    localparam logic [79:0] DEF_QNAN   = 80'hFFFF_C000_0000_0000_0000;
    localparam logic [79:0] POS_ZERO   = 80'h0000_0000_0000_0000_0000;

    typedef struct packed {
        logic [79:0] value;
        logic [3:0]  flags;
    } res_t;

    typedef struct packed {
        logic special;
        res_t res;
    } check_t;

    function automatic check_t classify(input logic [78:0] op);
        check_t c;
        c.special   = 1'b1;
        c.res.value = POS_ZERO;
        c.res.flags = 4'b0000;
        if (op[78:64] == 15'h0000) begin
            // Denormal inputs square to far below the normal range.
            if (op[63:0] != 64'h0) begin
                c.res.flags = FLAG_UF | FLAG_NX;
            end else begin
                c.res.flags = 4'b0000;
            end
        end else if (op[63] == 1'b0) begin
            c.res.value = DEF_QNAN;
            c.res.flags = FLAG_NV;
        end else if (op[78:64] == 15'h7FFF) begin
            if (op[62:0] == 63'h0) begin
                c.res.value = POS_INF;
            end else begin
                c.res.value = {1'b0, op[78:63], 1'b1, op[61:0]};
                c.res.flags = op[62] ? 4'b0000 : FLAG_NV;
            end
        end else begin
            c.special = 1'b0;
        end
        return c;
    endfunction

    function automatic res_t round_product(input logic [127:0] p,
                                           input logic [14:0]  e_in,
                                           input logic         sign);
        res_t               r;
        logic [63:0]        m;
        logic               guard;
        logic               sticky;
        logic               inexact;
        logic signed [16:0] e;
        logic [64:0]        m_inc;
        m_inc = 65'd0;
        if (p[127]) begin
            m      = p[127:64];
            guard  = p[63];
            sticky = |p[62:0];
            e      = $signed({1'b0, e_in, 1'b0}) - 17'sd16383 + 17'sd1;
        end else begin
            m      = p[126:63];
            guard  = p[62];
            sticky = |p[61:0];
            e      = $signed({1'b0, e_in, 1'b0}) - 17'sd16383;
        end
        if (guard & (sticky | m[0])) begin
            m_inc = {1'b0, m} + 65'd1;
            if (m_inc[64]) begin
                m = 64'h8000_0000_0000_0000;
                e = e + 17'sd1;
            end else begin
                m = m_inc[63:0];
            end
        end else begin
            m = m;
        end
        inexact = guard | sticky;
        if (e >= 17'sd32767) begin
            r.value = POS_INF;
            r.flags = FLAG_OF | FLAG_NX;
        end else if (e <= 17'sd0) begin
            r.value = POS_ZERO;
            r.flags = FLAG_UF | FLAG_NX;
        end else begin
            r.value = {sign, e[14:0], m};
            r.flags = {3'b000, inexact};
        end
        return r;
    endfunction

    state_t        state_r;
    logic [79:0]   op_r;
    logic [63:0]   mcand_r;
    logic [63:0]   mplier_r;
    logic [127:0]  acc_r;
    logic [6:0]    cnt_r;
    logic [79:0]   result_r;
    logic          done_r;
    logic [3:0]    flags_r;

    logic [64:0]   sum_s;
    logic          sign_s;
    check_t        chk_s;
    res_t          rnd_s;

    // Shift-add step, operand classification and rounding of the finished product.
    always_comb begin
        sum_s  = {1'b0, acc_r[127:64]} + (mplier_r[0] ? {1'b0, mcand_r} : 65'd0);
        sign_s = op_r[79] ^ op_r[79];
        chk_s  = classify(op_r[78:0]);
        rnd_s  = round_product(acc_r, op_r[78:64], sign_s);
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            op_r     <= 80'h0;
            mcand_r  <= 64'h0;
            mplier_r <= 64'h0;
            acc_r    <= 128'h0;
            cnt_r    <= 7'd0;
            result_r <= 80'h0;
            done_r   <= 1'b0;
            flags_r  <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.enable) begin
                        op_r    <= bus.operand_in;
                        flags_r <= 4'b0000;
                        state_r <= ST_CHECK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (chk_s.special) begin
                        result_r <= chk_s.res.value;
                        flags_r  <= chk_s.res.flags;
                        done_r   <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        mcand_r  <= op_r[63:0];
                        mplier_r <= op_r[63:0];
                        acc_r    <= 128'h0;
                        cnt_r    <= 7'd0;
                        state_r  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    // Product shifts right as each multiplier bit is consumed.
                    acc_r    <= {sum_s, acc_r[63:1]};
                    mplier_r <= {1'b0, mplier_r[63:1]};
                    cnt_r    <= cnt_r + 7'd1;
                    if (cnt_r == 7'd63) begin
                        state_r <= ST_ROUND;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
                ST_ROUND: begin
                    result_r <= rnd_s.value;
                    flags_r  <= rnd_s.flags;
                    done_r   <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    if (!bus.enable) begin
                        done_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.result         = result_r;
    assign bus.done           = done_r;
    assign bus.flag_invalid   = flags_r[3];
    assign bus.flag_overflow  = flags_r[2];
    assign bus.flag_underflow = flags_r[1];
    assign bus.flag_inexact   = flags_r[0];

endmodule

// File: tb/tb_fpu_square_seq.sv
// Scoreboard bench for fpu_square_seq: directed FP80 vectors with hand-computed squares.
module tb_fpu_square_seq;

    typedef struct {
        logic [79:0] res;
        logic [3:0]  flags;
        int          lat;
        int          t0;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic done_prev = 1'b0;
    exp_t sb_q[$];

    fpu_square_seq_if bus();

    fpu_square_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.flag_invalid, bus.flag_overflow, bus.flag_underflow, bus.flag_inexact};
    endfunction

    // Monitor: every rising done pops the scoreboard and compares.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1 && done_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %h with empty scoreboard", bus.result);
            end else begin
                e = sb_q.pop_front();
                chk("result", bus.result, e.res);
                chk("flags", {76'h0, flags_now()}, {76'h0, e.flags});
                chk_int("latency", cyc - e.t0, e.lat);
            end
        end
        done_prev = bus.done;
    end

    task automatic wait_done_level(input logic lvl);
        int n = 0;
        while (bus.done !== lvl && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL done_timeout: done stuck at %b, required %b", bus.done, lvl);
        end
    endtask

    task automatic start_op(input logic [79:0] op, input logic push,
                            input logic [79:0] r, input logic [3:0] f, input int lat);
        exp_t e;
        @(negedge clk);
        bus.operand_in = op;
        bus.enable     = 1'b1;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        if (push) begin
            e.res   = r;
            e.flags = f;
            e.lat   = lat;
            e.t0    = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic run_op(input logic [79:0] op, input logic [79:0] r,
                          input logic [3:0] f, input int lat);
        start_op(op, 1'b1, r, f, lat);
        wait_done_level(1'b1);
        wait_done_level(1'b0);
        chk("held_result", bus.result, r);
    endtask

    initial begin
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.operand_in = 80'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", bus.result, 80'h0);
        chk("reset_done_flags", {75'h0, bus.done, flags_now()}, 80'h0);
        @(negedge clk);
        reset = 1'b0;

        // flags: {invalid, overflow, underflow, inexact}
        run_op(80'h4000_C000_0000_0000_0000, 80'h4002_9000_0000_0000_0000, 4'b0000, 66);
        run_op(80'h3FFF_FFFF_FFFF_FFFF_FFFF, 80'h4000_FFFF_FFFF_FFFF_FFFE, 4'b0001, 66);
        run_op(80'h3FFF_C000_0000_0000_0001, 80'h4000_9000_0000_0000_0002, 4'b0001, 66);
        run_op(80'hC000_8000_0000_0000_0000, 80'h4001_8000_0000_0000_0000, 4'b0000, 66);
        run_op(80'h3FFF_8000_0000_0000_0000, 80'h3FFF_8000_0000_0000_0000, 4'b0000, 66);
        run_op(80'h0000_0000_0000_0000_0000, 80'h0000_0000_0000_0000_0000, 4'b0000, 1);
        run_op(80'h6000_8000_0000_0000_0000, 80'h7FFF_8000_0000_0000_0000, 4'b0101, 66);
        run_op(80'h5FFF_8000_0000_0000_0000, 80'h7FFF_8000_0000_0000_0000, 4'b0101, 66);
        run_op(80'h5FFE_8000_0000_0000_0000, 80'h7FFD_8000_0000_0000_0000, 4'b0000, 66);
        run_op(80'h1000_8000_0000_0000_0000, 80'h0000_0000_0000_0000_0000, 4'b0011, 66);
        run_op(80'h1FFF_8000_0000_0000_0000, 80'h0000_0000_0000_0000_0000, 4'b0011, 66);
        run_op(80'h2000_8000_0000_0000_0000, 80'h0001_8000_0000_0000_0000, 4'b0000, 66);
        run_op(80'h7FFF_8000_0000_0000_0001, 80'h7FFF_C000_0000_0000_0001, 4'b1000, 1);
        run_op(80'hFFFF_C000_0000_0000_0005, 80'h7FFF_C000_0000_0000_0005, 4'b0000, 1);
        run_op(80'h4000_4000_0000_0000_0000, 80'hFFFF_C000_0000_0000_0000, 4'b1000, 1);
        run_op(80'hFFFF_8000_0000_0000_0000, 80'h7FFF_8000_0000_0000_0000, 4'b0000, 1);
        run_op(80'h0000_0000_0000_0000_0001, 80'h0000_0000_0000_0000_0000, 4'b0011, 1);

        // Enable held high: done must persist until enable drops.
        start_op(80'hC000_8000_0000_0000_0000, 1'b1, 80'h4001_8000_0000_0000_0000, 4'b0000, 66);
        bus.enable = 1'b1;
        wait_done_level(1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("done_held", {79'h0, bus.done}, 80'h1);
        end
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        chk("done_drop", {79'h0, bus.done}, 80'h0);

        // A second enable while multiplying is ignored.
        start_op(80'h4000_C000_0000_0000_0000, 1'b1, 80'h4002_9000_0000_0000_0000, 4'b0000, 66);
        repeat (10) @(posedge clk);
        start_op(80'h0000_0000_0000_0000_0000, 1'b0, 80'h0, 4'b0000, 0);
        wait_done_level(1'b1);
        wait_done_level(1'b0);
        repeat (10) @(negedge clk);

        // Reset in the middle of MUL clears everything.
        start_op(80'h4000_C000_0000_0000_0000, 1'b0, 80'h0, 4'b0000, 0);
        repeat (31) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_result", bus.result, 80'h0);
        chk("midreset_done_flags", {75'h0, bus.done, flags_now()}, 80'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        chk("no_done_after_reset", {79'h0, bus.done}, 80'h0);

        run_op(80'h4000_C000_0000_0000_0000, 80'h4002_9000_0000_0000_0000, 4'b0000, 66);

        chk_int("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
